hdlc_rx_deframer: RTL and testbench

Receive-side counterpart of the HDLC transmit chain. It takes a serial bit stream qualified by a clock enable and hunts for flags (0x7E). It removes stuffed zeros, assembles LSB-first bytes and checks the CRC-16/X.25 FCS. Good frames are unpacked into a register address/data pair; bad frames are reported. It sits between the line input decoder and the register-access logic.

---
 rtl/hdlc_rx_deframer_if.sv | 40 ++++
 rtl/hdlc_rx_deframer.sv | 165 ++++++++++++++++
 tb/tb_hdlc_rx_deframer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdlc_rx_deframer_if.sv
// Line-side bit stream in, decoded register access and frame status out.
// The deframer takes the slave side; the line decoder drives the master side.
interface hdlc_rx_deframer_if;
    logic        ce;
    logic        bit_in;
    logic [31:0] rx_address;
    logic [31:0] rx_data;
    logic        frame_valid;
    logic        crc_error;
    logic        length_error;
    logic        abort;
    logic        busy;
    logic [31:0] crc_counter;

    modport master (
        output ce,
        output bit_in,
        input  rx_address,
        input  rx_data,
        input  frame_valid,
        input  crc_error,
        input  length_error,
        input  abort,
        input  busy,
        input  crc_counter
    );

    modport slave (
        input  ce,
        input  bit_in,
        output rx_address,
        output rx_data,
        output frame_valid,
        output crc_error,
        output length_error,
        output abort,
        output busy,
        output crc_counter
    );
endinterface

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag hunt, zero destuffing, LSB-first byte assembly,
// CRC-16/X.25 check and unpacking of an address/data register access.
module hdlc_rx_deframer #(
    parameter int PAYLOAD_BYTES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    hdlc_rx_deframer_if.slave rx
);

    typedef enum logic {HUNT, RECV} state_t;

    localparam logic [4:0]  LEN_OK  = 5'(PAYLOAD_BYTES + 2);
    localparam logic [4:0]  LEN_OVF = 5'(PAYLOAD_BYTES + 3);
    localparam logic [15:0] RESIDUE = 16'hF0B8;

    state_t          state_q, state_d;
    logic [7:0]      raw_q, raw_d;
    logic [2:0]      ones_q, ones_d;
    logic [2:0]      part_q, part_d;
    logic [7:0]      byte_q, byte_d;
    logic [4:0]      bcnt_q, bcnt_d;
    logic [15:0]     crc_q, crc_d;
    logic [7:0][7:0] buf_q, buf_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic [31:0]     cnt_q, cnt_d;
    logic            fv_q, fv_d;
    logic            cerr_q, cerr_d;
    logic            lerr_q, lerr_d;
    logic            ab_q, ab_d;
    logic            busy_q, busy_d;
    logic            is_flag, is_abort, is_stuff;

    function automatic logic [15:0] crc_upd(input logic [15:0] c,
                                            input logic [7:0]  b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ b[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        raw_d    = raw_q;
        ones_d   = ones_q;
        part_d   = part_q;
        byte_d   = byte_q;
        bcnt_d   = bcnt_q;
        crc_d    = crc_q;
        buf_d    = buf_q;
        addr_d   = addr_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        fv_d     = 1'b0;
        cerr_d   = 1'b0;
        lerr_d   = 1'b0;
        ab_d     = 1'b0;
        is_flag  = 1'b0;
        is_abort = 1'b0;
        is_stuff = 1'b0;
        if (rx.ce) begin
            raw_d = {rx.bit_in, raw_q[7:1]};
            if (rx.bit_in) begin
                ones_d = (ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1;
            end else begin
                ones_d = 3'd0;
            end
            is_flag  = (raw_d == 8'h7E);
            // Only the 6->7 transition aborts, so a long run of ones pulses once
            is_abort = rx.bit_in && (ones_q == 3'd6);
            is_stuff = !rx.bit_in && (ones_q == 3'd5);
            if (is_abort) begin
                ab_d    = 1'b1;
                state_d = HUNT;
            end else if (is_flag) begin
                if (state_q == RECV) begin
                    if (bcnt_q == 5'd0 && part_q == 3'd7) begin
                        fv_d = 1'b0;
                    end else if (bcnt_q == LEN_OK && part_q == 3'd7) begin
                        if (crc_q == RESIDUE) begin
                            fv_d   = 1'b1;
                            addr_d = buf_q[3:0];
                            data_d = buf_q[7:4];
                        end else begin
                            cerr_d = 1'b1;
                            cnt_d  = cnt_q + 32'd1;
                        end
                    end else begin
                        lerr_d = 1'b1;
                    end
                end
                state_d = RECV;
                part_d  = 3'd0;
                bcnt_d  = 5'd0;
                crc_d   = 16'hFFFF;
            end else if (!is_stuff && state_q == RECV) begin
                byte_d = {rx.bit_in, byte_q[7:1]};
                part_d = part_q + 3'd1;
                if (part_q == 3'd7) begin
                    crc_d = crc_upd(crc_q, byte_d);
                    if (bcnt_q < 5'd8) begin
                        buf_d[bcnt_q[2:0]] = byte_d;
                    end
                    bcnt_d = bcnt_q + 5'd1;
                    if (bcnt_d == LEN_OVF) begin
                        lerr_d  = 1'b1;
                        state_d = HUNT;
                    end
                end
            end
        end
        busy_d = (state_d == RECV) && (bcnt_d != 5'd0 || part_d != 3'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HUNT;
            raw_q   <= '0;
            ones_q  <= '0;
            part_q  <= '0;
            byte_q  <= '0;
            bcnt_q  <= '0;
            crc_q   <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            fv_q    <= 1'b0;
            cerr_q  <= 1'b0;
            lerr_q  <= 1'b0;
            ab_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            raw_q   <= raw_d;
            ones_q  <= ones_d;
            part_q  <= part_d;
            byte_q  <= byte_d;
            bcnt_q  <= bcnt_d;
            crc_q   <= crc_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            fv_q    <= fv_d;
            cerr_q  <= cerr_d;
            lerr_q  <= lerr_d;
            ab_q    <= ab_d;
            busy_q  <= busy_d;
        end
    end

    assign rx.rx_address   = addr_q;
    assign rx.rx_data      = data_q;
    assign rx.frame_valid  = fv_q;
    assign rx.crc_error    = cerr_q;
    assign rx.length_error = lerr_q;
    assign rx.abort        = ab_q;
    assign rx.busy         = busy_q;
    assign rx.crc_counter  = cnt_q;

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Directed bench for hdlc_rx_deframer: framing, stuffing, CRC and reset cases.
module tb_hdlc_rx_deframer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hdlc_rx_deframer_if bus ();
    hdlc_rx_deframer_if bus9 ();

    assign bus9.ce     = bus.ce;
    assign bus9.bit_in = bus.bit_in;

    hdlc_rx_deframer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (bus)
    );

    hdlc_rx_deframer #(.PAYLOAD_BYTES(9)) dut9 (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (bus9)
    );

    int n_chk = 0;
    int n_err = 0;
    int fv_n = 0, ce_n = 0, le_n = 0, ab_n = 0, fv9_n = 0, mx_n = 0;
    int b_fv, b_ce, b_le, b_ab, b_fv9;

    bit         tx[$];
    logic [7:0] pl[$];
    int         st_ones;
    int         mark;
    int         stuff_pos;

    always @(negedge clk) begin
        if (bus.frame_valid)   fv_n++;
        if (bus.crc_error)     ce_n++;
        if (bus.length_error)  le_n++;
        if (bus.abort)         ab_n++;
        if (bus9.frame_valid)  fv9_n++;
        if (int'(bus.frame_valid) + int'(bus.crc_error) +
            int'(bus.length_error) + int'(bus.abort) > 1) mx_n++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc16(input logic [15:0] c,
                                          input logic [7:0]  b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 16'h8408;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic add_flag();
        logic [7:0] f;
        f = 8'h7E;
        for (int i = 0; i < 8; i++) tx.push_back(f[i]);
        st_ones = 0;
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            tx.push_back(b[i]);
            if (b[i]) begin
                st_ones++;
                if (st_ones == 5) begin
                    if (stuff_pos < 0) stuff_pos = tx.size();
                    tx.push_back(1'b0);
                    st_ones = 0;
                end
            end else begin
                st_ones = 0;
            end
        end
    endtask

    task automatic set_pl(input logic [31:0] a, input logic [31:0] d);
        pl.delete();
        for (int i = 0; i < 4; i++) pl.push_back(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) pl.push_back(d[8*i +: 8]);
    endtask

    task automatic add_frame(input int flip_idx, input logic [7:0] mask);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (pl[i]) c = crc16(c, pl[i]);
        c = ~c;
        foreach (pl[i]) begin
            add_byte((i == flip_idx) ? (pl[i] ^ mask) : pl[i]);
            if (i == 4) mark = tx.size();
        end
        add_byte(c[7:0]);
        add_byte(c[15:8]);
    endtask

    task automatic send_range(input int lo, input int hi, input int per);
        for (int i = lo; i < hi; i++) begin
            bus.bit_in = tx[i];
            bus.ce = 1'b1;
            @(negedge clk);
            bus.ce = 1'b0;
            repeat (per - 1) @(negedge clk);
        end
    endtask

    task automatic send(input int per);
        send_range(0, tx.size(), per);
        tx.delete();
        repeat (4) @(negedge clk);
    endtask

    task automatic snap();
        b_fv = fv_n; b_ce = ce_n; b_le = le_n; b_ab = ab_n; b_fv9 = fv9_n;
        tx.delete();
        stuff_pos = -1;
        st_ones = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.ce = 1'b0;
        bus.bit_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_addr", bus.rx_address, 32'h0);
        chk("rst_data", bus.rx_data, 32'h0);
        chk("rst_cnt", bus.crc_counter, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // good frame, ce every third cycle
        snap();
        set_pl(32'h12345678, 32'hDEADBEEF);
        add_flag(); add_frame(-1, 8'h00); add_flag();
        send(3);
        chk("good_fv", 32'(fv_n - b_fv), 32'd1);
        chk("good_addr", bus.rx_address, 32'h12345678);
        chk("good_data", bus.rx_data, 32'hDEADBEEF);
        chk("good_cnt", bus.crc_counter, 32'd0);
        chk("good_other", 32'(ce_n - b_ce + le_n - b_le + ab_n - b_ab), 32'd0);
        chk("good_busy", 32'(bus.busy), 32'd0);

        // check value "123456789" -> FCS 0x906E, sent 6E then 90
        snap();
        add_flag();
        for (int i = 0; i < 9; i++) add_byte(8'(8'h31 + i));
        add_byte(8'h6E); add_byte(8'h90);
        add_flag();
        send(1);
        chk("kat_fv", 32'(fv9_n - b_fv9), 32'd1);
        chk("kat_addr", bus9.rx_address, 32'h34333231);
        chk("kat_data", bus9.rx_data, 32'h38373635);

        // stuffing-heavy frame
        snap();
        set_pl(32'h7E7E7E7E, 32'hFFFFFFFF);
        add_flag(); add_frame(-1, 8'h00); add_flag();
        send(2);
        chk("stuff_fv", 32'(fv_n - b_fv), 32'd1);
        chk("stuff_addr", bus.rx_address, 32'h7E7E7E7E);
        chk("stuff_data", bus.rx_data, 32'hFFFFFFFF);

        // same frame missing one stuffed zero
        snap();
        add_flag(); add_frame(-1, 8'h00); add_flag();
        tx.delete(stuff_pos);
        send(1);
        chk("nostuff_fv", 32'(fv_n - b_fv), 32'd0);
        chk("nostuff_err", 32'((ab_n - b_ab + le_n - b_le) > 0), 32'd1);

        // data bit 5 flipped
        snap();
        set_pl(32'h12345678, 32'hDEADBEEF);
        add_flag(); add_frame(4, 8'h20); add_flag();
        send(1);
        chk("crc_pulse", 32'(ce_n - b_ce), 32'd1);
        chk("crc_fv", 32'(fv_n - b_fv), 32'd0);
        chk("crc_cnt", bus.crc_counter, 32'd1);
        chk("crc_addr", bus.rx_address, 32'h7E7E7E7E);
        chk("crc_data", bus.rx_data, 32'hFFFFFFFF);

        snap();
        set_pl(32'hA5A5A5A5, 32'h0BADF00D);
        add_flag(); add_frame(-1, 8'h00); add_flag();
        send(1);
        chk("after_crc_fv", 32'(fv_n - b_fv), 32'd1);
        chk("after_crc_data", bus.rx_data, 32'h0BADF00D);
        chk("after_crc_cnt", bus.crc_counter, 32'd1);

        // seven ones mid-frame, then a fresh good frame
        snap();
        add_flag(); add_byte(8'h11); add_byte(8'h22);
        for (int i = 0; i < 7; i++) tx.push_back(1'b1);
        set_pl(32'hCAFEF00D, 32'h00C0FFEE);
        add_flag(); add_frame(-1, 8'h00); add_flag();
        send(1);
        chk("abort_pulse", 32'(ab_n - b_ab), 32'd1);
        chk("abort_fv", 32'(fv_n - b_fv), 32'd1);
        chk("abort_addr", bus.rx_address, 32'hCAFEF00D);

        // nine payload bytes on the default build
        snap();
        set_pl(32'h01010101, 32'h02020202);
        pl.push_back(8'h03);
        add_flag(); add_frame(-1, 8'h00); add_flag();
        send(1);
        chk("len_pulse", 32'(le_n - b_le), 32'd1);
        chk("len_fv", 32'(fv_n - b_fv), 32'd0);

        // two frames sharing one flag
        snap();
        set_pl(32'h11112222, 32'h33334444);
        add_flag(); add_frame(-1, 8'h00); add_flag();
        set_pl(32'h55556666, 32'h77778888);
        add_frame(-1, 8'h00); add_flag();
        send(1);
        chk("b2b_fv", 32'(fv_n - b_fv), 32'd2);
        chk("b2b_addr", bus.rx_address, 32'h55556666);
        chk("b2b_data", bus.rx_data, 32'h77778888);

        // idle flags
        snap();
        for (int i = 0; i < 4; i++) add_flag();
        send(1);
        chk("flags_quiet",
            32'(fv_n - b_fv + ce_n - b_ce + le_n - b_le + ab_n - b_ab), 32'd0);

        // reset after five payload bytes
        snap();
        set_pl(32'h01020304, 32'h05060708);
        add_flag(); add_frame(-1, 8'h00); add_flag();
        send_range(0, mark, 1);
        @(negedge clk);
        chk("mid_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_addr", bus.rx_address, 32'h0);
        chk("mrst_data", bus.rx_data, 32'h0);
        chk("mrst_cnt", bus.crc_counter, 32'h0);
        chk("mrst_busy", 32'(bus.busy), 32'h0);
        send_range(mark, tx.size() - 8, 1);
        repeat (4) @(negedge clk);
        chk("mrst_quiet",
            32'(fv_n - b_fv + ce_n - b_ce + le_n - b_le + ab_n - b_ab), 32'd0);
        snap();
        set_pl(32'h0A0B0C0D, 32'h01234567);
        add_flag(); add_frame(-1, 8'h00); add_flag();
        send(1);
        chk("mrst_fv", 32'(fv_n - b_fv), 32'd1);
        chk("mrst_new_addr", bus.rx_address, 32'h0A0B0C0D);
        chk("mrst_new_data", bus.rx_data, 32'h01234567);

        chk("mutex", 32'(mx_n), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
